frame_tx_scheduler: RTL

//  Shares the single framing/whitening/serializing chain between NUM_REQ frame sources.

---
 rtl/framing_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/frame_tx_scheduler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/framing_pkg.sv
// Shared constants and state encoding for the frame transmit path (scheduler, CRC framer).
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package framing_pkg;

    localparam int MAX_PSDU    = 127;
    localparam int CRC_BYTES   = 2;
    localparam int PHR_LEN_W   = 7;
    localparam int MAX_PAYLOAD = MAX_PSDU - CRC_BYTES;

    // Frame-level sequencing, shared with the CRC framer so both sides decode the same encoding
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PHR   = 3'd1,
        PSDU  = 3'd2,
        DRAIN = 3'd3,
        GAP   = 3'd4
    } frame_state_t;

    // A payload must be non-empty and leave room for the CRC inside MAX_PSDU
    function automatic logic len_ok(input logic [PHR_LEN_W-1:0] len);
        return (len != '0) && (int'(len) <= MAX_PAYLOAD);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request strictly after ptr, wrapping, as a one-hot grant.
// Latency: combinational, zero cycles; the caller registers the grant and advances ptr.
// Backpressure: none; the grant is only a suggestion until the caller accepts it.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    int idx;

    // Scan ptr+1, ptr+2, ... so the most recently served source is considered last
    always_comb begin
        gnt = '0;
        idx = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if ((gnt == '0) && req[idx]) begin
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_tx_scheduler.sv
// Arbitrates NUM_REQ frame sources onto one serializer chain: PHR byte, then payload bytes.
// Latency: PHR one clock after arbitration, payload byte j at PHR + j*BYTE_GAP clocks.
// Backpressure: none downstream; sources are held off by withholding grant until CRC + IFS drain.
module frame_tx_scheduler
    import framing_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int BYTE_GAP   = 8,
    parameter int IFS_CYCLES = 96
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [7*NUM_REQ-1:0]   req_len,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_rd,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     err,
    output logic [7:0]             phr_psdu_out,
    output logic                   phr_psdu_out_valid,
    output logic                   busy
);

    localparam int PTR_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DRAIN_CYCLES = CRC_BYTES * BYTE_GAP;
    localparam int GAP_MAX_A    = (BYTE_GAP > DRAIN_CYCLES) ? BYTE_GAP : DRAIN_CYCLES;
    localparam int GAP_MAX      = (GAP_MAX_A > IFS_CYCLES) ? GAP_MAX_A : IFS_CYCLES;
    localparam int CNT_W        = $clog2(GAP_MAX + 1);

    frame_state_t             state;
    logic [PTR_W-1:0]         ptr;
    logic [NUM_REQ-1:0]       sel;
    logic [PHR_LEN_W-1:0]     len_q;
    logic [PHR_LEN_W-1:0]     byte_cnt;
    logic [CNT_W-1:0]         gap_cnt;

    logic [NUM_REQ-1:0]       arb_gnt;
    logic [PTR_W-1:0]         arb_idx;
    logic [PHR_LEN_W-1:0]     arb_len;
    logic [7:0]               sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    // Index and length of the arbitration winner, for the pointer update and length latch
    always_comb begin
        arb_idx = '0;
        arb_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                arb_idx = PTR_W'(i);
                arb_len = req_len[7*i +: 7];
            end
        end
    end

    // Payload byte of the source currently owning the chain
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = req_data[8*i +: 8];
            end
        end
    end

    // Frame sequencer: arbitrate, check length, emit PHR, pace payload, then hold off for CRC + IFS
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            ptr                <= PTR_W'(NUM_REQ - 1);
            sel                <= '0;
            len_q              <= '0;
            byte_cnt           <= '0;
            gap_cnt            <= '0;
            grant              <= '0;
            req_rd             <= '0;
            done               <= '0;
            err                <= '0;
            phr_psdu_out       <= '0;
            phr_psdu_out_valid <= 1'b0;
        end else begin
            req_rd             <= '0;
            done               <= '0;
            err                <= '0;
            phr_psdu_out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (|req) begin
                        sel      <= arb_gnt;
                        ptr      <= arb_idx;
                        len_q    <= arb_len;
                        byte_cnt <= arb_len;
                        state    <= PHR;
                    end
                end

                // Rejection is resolved here so err lands on the clock the PHR would have
                PHR: begin
                    if (!len_ok(len_q)) begin
                        err   <= sel;
                        state <= IDLE;
                    end else begin
                        grant              <= sel;
                        phr_psdu_out       <= {1'b0, len_q + PHR_LEN_W'(CRC_BYTES)};
                        phr_psdu_out_valid <= 1'b1;
                        gap_cnt            <= CNT_W'(BYTE_GAP - 1);
                        state              <= PSDU;
                    end
                end

                PSDU: begin
                    if (gap_cnt == '0) begin
                        phr_psdu_out       <= sel_data;
                        phr_psdu_out_valid <= 1'b1;
                        req_rd             <= grant;
                        byte_cnt           <= (byte_cnt != '0) ? byte_cnt - 7'd1 : '0;
                        if (byte_cnt <= 7'd1) begin
                            done    <= grant;
                            gap_cnt <= CNT_W'(DRAIN_CYCLES - 1);
                            state   <= DRAIN;
                        end else begin
                            gap_cnt <= CNT_W'(BYTE_GAP - 1);
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                // Framer shifts out the CRC while the chain stays owned by nobody
                DRAIN: begin
                    grant <= '0;
                    if (gap_cnt == '0) begin
                        gap_cnt <= CNT_W'(IFS_CYCLES - 1);
                        state   <= GAP;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
